// File: rtl/mix_columns_seq.sv
// Iterative forward/inverse MixColumns over an NB-column state, COLS_PER_CYCLE columns per clock.
// Optional MIX_COLUMNS_SEQ_BYPASS_EN adds bypass_i to pass a block through untransformed.
module mix_columns_seq #(
  parameter int NB             = 4,
  parameter int COLS_PER_CYCLE = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              enc_dec,
  input  logic [NB*32-1:0]  state_i,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [NB*32-1:0]  state_o,
  output logic              busy
`ifdef MIX_COLUMNS_SEQ_BYPASS_EN
  ,
  input  logic              bypass_i
`endif
);

  // Handshake: a transfer happens on a rising edge where valid and ready are both
  // high; in_valid is only looked at in IDLE, and the result holds while out_ready is low.

  localparam int CW = $clog2(NB) + 1;

  if ((NB != 4 && NB != 6 && NB != 8) || COLS_PER_CYCLE < 1 ||
      (NB % COLS_PER_CYCLE) != 0) begin : g_bad_cfg
    $error("mix_columns_seq: NB must be 4/6/8 and divisible by COLS_PER_CYCLE");
  end

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPUTE = 2'd1,
    DONE    = 2'd2
  } state_t;

  state_t             state;
  state_t             state_next;
  logic [NB*32-1:0]   work;
  logic [NB*32-1:0]   work_next;
  logic               mode;
  logic [CW-1:0]      cnt;
  logic               last_group;
  logic               take_bypass;
  logic [31:0]        grp_out [COLS_PER_CYCLE];

`ifdef MIX_COLUMNS_SEQ_BYPASS_EN
  assign take_bypass = bypass_i;
`else
  assign take_bypass = 1'b0;
`endif

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Coefficients here never exceed 4'hf, so b*c is a sum of b, 2b, 4b, 8b.
  function automatic logic [7:0] gf_mul(input logic [7:0] b, input logic [3:0] c);
    logic [7:0] x1;
    logic [7:0] x2;
    logic [7:0] x3;
    x1 = xtime(b);
    x2 = xtime(x1);
    x3 = xtime(x2);
    return ({8{c[0]}} & b) ^ ({8{c[1]}} & x1) ^ ({8{c[2]}} & x2) ^ ({8{c[3]}} & x3);
  endfunction

  function automatic logic [31:0] mix_col(input logic [31:0] col, input logic enc);
    logic [7:0] a0, a1, a2, a3;
    logic [3:0] c0, c1, c2, c3;
    logic [7:0] r0, r1, r2, r3;
    a0 = col[31:24];
    a1 = col[23:16];
    a2 = col[15:8];
    a3 = col[7:0];
    c0 = enc ? 4'h2 : 4'he;
    c1 = enc ? 4'h3 : 4'hb;
    c2 = enc ? 4'h1 : 4'hd;
    c3 = enc ? 4'h1 : 4'h9;
    // Row i uses coefficient index (j - i) mod 4 for input byte j.
    r0 = gf_mul(a0, c0) ^ gf_mul(a1, c1) ^ gf_mul(a2, c2) ^ gf_mul(a3, c3);
    r1 = gf_mul(a0, c3) ^ gf_mul(a1, c0) ^ gf_mul(a2, c1) ^ gf_mul(a3, c2);
    r2 = gf_mul(a0, c2) ^ gf_mul(a1, c3) ^ gf_mul(a2, c0) ^ gf_mul(a3, c1);
    r3 = gf_mul(a0, c1) ^ gf_mul(a1, c2) ^ gf_mul(a2, c3) ^ gf_mul(a3, c0);
    return {r0, r1, r2, r3};
  endfunction

  // One mixer per group lane; each lane muxes in the column cnt+g.
  for (genvar g = 0; g < COLS_PER_CYCLE; g++) begin : g_lane
    logic [31:0] sel;
    always_comb begin
      sel = '0;
      for (int c = 0; c < NB; c++) begin
        if (CW'(c) == cnt + CW'(g)) sel = work[NB*32-1-32*c -: 32];
      end
    end
    assign grp_out[g] = mix_col(sel, mode);
  end

  always_comb begin
    work_next = work;
    for (int c = 0; c < NB; c++) begin
      for (int g = 0; g < COLS_PER_CYCLE; g++) begin
        if (CW'(c) == cnt + CW'(g)) work_next[NB*32-1-32*c -: 32] = grp_out[g];
      end
    end
  end

  assign last_group = (cnt == CW'(NB - COLS_PER_CYCLE));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    busy       = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_next = take_bypass ? DONE : COMPUTE;
      end
      COMPUTE: begin
        busy = 1'b1;
        if (last_group) state_next = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // cnt wraps to 0 after the last group so it always stays a legal column index.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      work <= '0;
      mode <= 1'b0;
      cnt  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            work <= state_i;
            mode <= enc_dec;
            cnt  <= '0;
          end
        end
        COMPUTE: begin
          work <= work_next;
          cnt  <= last_group ? '0 : cnt + CW'(COLS_PER_CYCLE);
        end
        default: ;
      endcase
    end
  end

  // Only a finished block is ever visible on state_o.
  assign state_o = (state == DONE) ? work : '0;

endmodule

// File: tb/tb_mix_columns_seq.sv
// Directed bench for mix_columns_seq: NB=4/1-col and NB=8/2-col instances, known-answer vectors.
module tb_mix_columns_seq;

  localparam logic [127:0] ENC_IN  = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
  localparam logic [127:0] ENC_OUT = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
  localparam logic [127:0] SWP_IN  = 128'hc6c6c6c6_db135345_01010101_f20a225c;
  localparam logic [127:0] SWP_OUT = 128'hc6c6c6c6_8e4da1bc_01010101_9fdc589d;
  localparam logic [255:0] NB8_IN  = {32'hd4d4d4d5, 32'h2d26314c, {6{32'h01010101}}};
  localparam logic [255:0] NB8_OUT = {32'hd5d5d7d6, 32'h4d7ebdf8, {6{32'h01010101}}};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n;
  logic         v4, r4, ed4, ov4, or4, busy4;
  logic [127:0] si4, so4;
  logic         v8, r8, ed8, ov8, or8, busy8;
  logic [255:0] si8, so8;
`ifdef MIX_COLUMNS_SEQ_BYPASS_EN
  logic         byp4, byp8;
`endif

  int checks   = 0;
  int failures = 0;

  mix_columns_seq #(.NB(4), .COLS_PER_CYCLE(1)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(v4), .in_ready(r4), .enc_dec(ed4),
    .state_i(si4), .out_valid(ov4), .out_ready(or4), .state_o(so4), .busy(busy4)
`ifdef MIX_COLUMNS_SEQ_BYPASS_EN
    , .bypass_i(byp4)
`endif
  );

  mix_columns_seq #(.NB(8), .COLS_PER_CYCLE(2)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(v8), .in_ready(r8), .enc_dec(ed8),
    .state_i(si8), .out_valid(ov8), .out_ready(or8), .state_o(so8), .busy(busy8)
`ifdef MIX_COLUMNS_SEQ_BYPASS_EN
    , .bypass_i(byp8)
`endif
  );

  // Cycles from the accept edge until out_valid, sampled 1 time unit after each edge.
  task automatic wait4(output int lat);
    lat = 0;
    while (ov4 !== 1'b1 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic accept4(input logic enc, input logic [127:0] data);
    @(negedge clk);
    v4 = 1'b1; ed4 = enc; si4 = data;
    @(posedge clk); #1;
    v4 = 1'b0; ed4 = ~enc; si4 = '1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    #12;
    checks++; if (ov4 !== 1'b0) begin failures++; $display("FAIL reset_out_valid: got %b expected 0", ov4); end
    checks++; if (so4 !== '0) begin failures++; $display("FAIL reset_state_o: got %h expected 0", so4); end
    checks++; if (busy4 !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", busy4); end
    checks++; if (so8 !== '0) begin failures++; $display("FAIL reset_state_o_nb8: got %h expected 0", so8); end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    checks++; if (r4 !== 1'b1) begin failures++; $display("FAIL reset_in_ready: got %b expected 1", r4); end
    checks++; if (r8 !== 1'b1) begin failures++; $display("FAIL reset_in_ready_nb8: got %b expected 1", r8); end
  endtask

  task automatic test_encrypt;
    int lat;
    accept4(1'b1, ENC_IN);
    checks++; if (r4 !== 1'b0) begin failures++; $display("FAIL enc_in_ready_after_accept: got %b expected 0", r4); end
    wait4(lat);
    checks++; if (lat != 4) begin failures++; $display("FAIL enc_latency: got %0d expected 4", lat); end
    checks++; if (so4 !== ENC_OUT) begin failures++; $display("FAIL enc_result: got %h expected %h", so4, ENC_OUT); end
    checks++; if (busy4 !== 1'b1) begin failures++; $display("FAIL enc_busy_done: got %b expected 1", busy4); end
    @(negedge clk); or4 = 1'b1;
    @(posedge clk); #1;
    checks++; if (ov4 !== 1'b0) begin failures++; $display("FAIL enc_out_valid_drop: got %b expected 0", ov4); end
    checks++; if (r4 !== 1'b1) begin failures++; $display("FAIL enc_back_to_idle: got %b expected 1", r4); end
    @(negedge clk); or4 = 1'b0;
  endtask

  task automatic test_decrypt;
    int lat;
    accept4(1'b0, ENC_OUT);
    wait4(lat);
    checks++; if (lat != 4) begin failures++; $display("FAIL dec_latency: got %0d expected 4", lat); end
    checks++; if (so4 !== ENC_IN) begin failures++; $display("FAIL dec_result: got %h expected %h", so4, ENC_IN); end
    @(negedge clk); or4 = 1'b1;
    @(posedge clk); #1;
    checks++; if (ov4 !== 1'b0) begin failures++; $display("FAIL dec_out_valid_drop: got %b expected 0", ov4); end
    @(negedge clk); or4 = 1'b0;
  endtask

  task automatic test_nb8;
    int lat;
    int bad;
    @(negedge clk);
    v8 = 1'b1; ed8 = 1'b1; si8 = NB8_IN;
    @(posedge clk); #1;
    v8 = 1'b0; ed8 = 1'b0; si8 = '0;
    lat = 0; bad = 0;
    while (ov8 !== 1'b1 && lat < 40) begin
      if (r8 !== 1'b0) bad++;
      @(posedge clk); #1;
      lat++;
    end
    checks++; if (bad != 0) begin failures++; $display("FAIL nb8_in_ready_low: got %0d high cycles expected 0", bad); end
    checks++; if (lat != 4) begin failures++; $display("FAIL nb8_latency: got %0d expected 4", lat); end
    checks++; if (so8 !== NB8_OUT) begin failures++; $display("FAIL nb8_result: got %h expected %h", so8, NB8_OUT); end
    checks++; if (r8 !== 1'b0) begin failures++; $display("FAIL nb8_in_ready_done: got %b expected 0", r8); end
    @(negedge clk); or8 = 1'b1;
    @(posedge clk); #1;
    checks++; if (ov8 !== 1'b0) begin failures++; $display("FAIL nb8_out_valid_drop: got %b expected 0", ov8); end
    @(negedge clk); or8 = 1'b0;
  endtask

  task automatic test_back_pressure;
    int lat;
    int bad;
    accept4(1'b1, ENC_IN);
    wait4(lat);
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      v4 = (i == 3); si4 = SWP_IN; ed4 = 1'b1;
      @(posedge clk); #1;
      if (ov4 !== 1'b1 || so4 !== ENC_OUT) bad++;
    end
    v4 = 1'b0;
    checks++; if (bad != 0) begin failures++; $display("FAIL bp_hold_stable: got %0d unstable cycles expected 0", bad); end
    @(negedge clk); or4 = 1'b1;
    @(posedge clk); #1;
    checks++; if (r4 !== 1'b1) begin failures++; $display("FAIL bp_release_idle: got %b expected 1", r4); end
    @(negedge clk); or4 = 1'b0;
    accept4(1'b0, ENC_OUT);
    wait4(lat);
    checks++; if (so4 !== ENC_IN) begin failures++; $display("FAIL bp_next_block: got %h expected %h", so4, ENC_IN); end
    @(negedge clk); or4 = 1'b1;
    @(negedge clk); or4 = 1'b0;
  endtask

  task automatic test_reset_mid;
    int lat;
    int seen;
    accept4(1'b1, ENC_IN);
    @(posedge clk);
    @(negedge clk); rst_n = 1'b0;
    #1;
    checks++; if (ov4 !== 1'b0) begin failures++; $display("FAIL rmid_out_valid: got %b expected 0", ov4); end
    checks++; if (so4 !== '0) begin failures++; $display("FAIL rmid_state_o: got %h expected 0", so4); end
    checks++; if (busy4 !== 1'b0) begin failures++; $display("FAIL rmid_busy: got %b expected 0", busy4); end
    @(negedge clk); rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (ov4 !== 1'b0 || r4 !== 1'b1) seen++;
    end
    checks++; if (seen != 0) begin failures++; $display("FAIL rmid_idle_after: got %0d bad cycles expected 0", seen); end
    accept4(1'b1, SWP_IN);
    wait4(lat);
    checks++; if (lat != 4) begin failures++; $display("FAIL rmid_fresh_latency: got %0d expected 4", lat); end
    checks++; if (so4 !== SWP_OUT) begin failures++; $display("FAIL rmid_fresh_result: got %h expected %h", so4, SWP_OUT); end
    @(negedge clk); or4 = 1'b1;
    @(negedge clk); or4 = 1'b0;
  endtask

`ifdef MIX_COLUMNS_SEQ_BYPASS_EN
  task automatic test_bypass;
    int lat;
    logic [127:0] data;
    data = 128'h0123456789abcdeffedcba9876543210;
    @(negedge clk);
    byp4 = 1'b1; v4 = 1'b1; ed4 = 1'b1; si4 = data;
    @(posedge clk); #1;
    byp4 = 1'b0; v4 = 1'b0; si4 = '0;
    wait4(lat);
    checks++; if (lat != 0) begin failures++; $display("FAIL bypass_latency: got %0d expected 0 after accept sample", lat); end
    checks++; if (so4 !== data) begin failures++; $display("FAIL bypass_result: got %h expected %h", so4, data); end
    @(negedge clk); or4 = 1'b1;
    @(negedge clk); or4 = 1'b0;
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    v4 = 1'b0; ed4 = 1'b0; si4 = '0; or4 = 1'b0;
    v8 = 1'b0; ed8 = 1'b0; si8 = '0; or8 = 1'b0;
`ifdef MIX_COLUMNS_SEQ_BYPASS_EN
    byp4 = 1'b0; byp8 = 1'b0;
`endif
    test_reset;
    test_encrypt;
    test_decrypt;
    test_nb8;
    test_back_pressure;
    test_reset_mid;
`ifdef MIX_COLUMNS_SEQ_BYPASS_EN
    test_bypass;
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mix_columns_seq.md
Name: mix_columns_seq

Overview:
- Parametrised, iterative successor to the combinational 4-column MixColumns stage of the cipher unit.
- Supports Rijndael block widths Nb = 4..8 columns and both forward and inverse MixColumns.
- Processes COLS_PER_CYCLE columns per clock behind a valid/ready handshake, trading area for latency.
- Sits between ShiftRows and AddRoundKey in the round datapath.

Parameters:
- NB, 4, number of 32-bit state columns; legal values 4, 6, 8.
- COLS_PER_CYCLE, 1, columns transformed per compute cycle; must divide NB (elaboration-time assertion otherwise).

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  input state valid.
- in_ready  output  1  block can accept a state.
- enc_dec  input  1  1 = MixColumns (encrypt), 0 = InvMixColumns (decrypt); sampled at accept.
- state_i  input  NB*32  input state; column 0 = bits [NB*32-1 -: 32]; row 0 byte = column bits [31:24].
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts the result.
- state_o  output  NB*32  result state, same packing as state_i.
- busy  output  1  high in COMPUTE or DONE.

Behaviour:
- Reset (async, rst_n = 0): FSM to IDLE; out_valid = 0; state_o = 0; column counter = 0; in_ready = 1 once reset is released; busy = 0.
- FSM states:
  - IDLE: in_ready = 1. On in_valid && in_ready, latch state_i into the working register, latch enc_dec, clear the counter, go to COMPUTE.
  - COMPUTE: in_ready = 0. Each cycle, replace columns [cnt .. cnt+COLS_PER_CYCLE-1] of the working register with their transformed values, then cnt += COLS_PER_CYCLE. When the last group is written, go to DONE.
  - DONE: out_valid = 1 and state_o = working register. On out_ready, go to IDLE and drop out_valid the next cycle.
- Latency: with the accept edge E0, compute edges are E1..E(NB/COLS_PER_CYCLE), and out_valid is high immediately after the last of those. For NB=4, COLS_PER_CYCLE=1, the result appears 4 cycles after accept.
- Throughput: one block per NB/COLS_PER_CYCLE + 2 cycles, with out_ready held high.
- Per-column arithmetic, GF(2^8) with polynomial 0x11B:
  - Encrypt: circulant {02,03,01,01}.
  - Decrypt: circulant {0e,0b,0d,09}.
  - Row i output = XOR over j of coef[(j-i) mod 4] * a_j.
  - xtime(b) = (b<<1) ^ (b[7] ? 8'h1B : 0).
- in_valid while not IDLE: ignored, state_i not sampled. The source must hold the data until in_ready is high.
- Back-pressure: out_ready low in DONE holds state_o and out_valid stable indefinitely.
- enc_dec changing after accept: no effect on the block in flight.
- Reset mid-COMPUTE or in DONE: immediate abort to reset values; the partial result is discarded and never presented.
- state_o is driven only from the working register. Columns not yet processed are never exposed with out_valid = 1.

Optional Feature:
- Macro: MIX_COLUMNS_SEQ_BYPASS_EN.
- Defined:
  - Adds port bypass_i (input, 1 bit), sampled at accept.
  - If bypass_i = 1, the FSM goes IDLE -> DONE directly (out_valid high one cycle after accept) and state_o equals the unmodified state_i. This serves the final cipher round.
  - If bypass_i = 0, behaviour is as normal.
- Not defined: port bypass_i is absent and every accepted block goes through COMPUTE.

Test Plan:
1. NB=4, COLS_PER_CYCLE=1, enc_dec=1, columns db135345 f20a225c 01010101 c6c6c6c6 -> out_valid 4 cycles after accept; state_o = 8e4da1bc 9fdc589d 01010101 c6c6c6c6.
2. Same NB/COLS_PER_CYCLE, enc_dec=0, input 8e4da1bc 9fdc589d 01010101 c6c6c6c6 -> state_o = db135345 f20a225c 01010101 c6c6c6c6.
3. NB=8, COLS_PER_CYCLE=2, enc_dec=1, columns d4d4d4d5, 2d26314c, then 01010101 x6 -> out_valid after 4 compute cycles; state_o = d5d5d7d6 4d7ebdf8 01010101 x6; in_ready = 0 throughout.
4. Back-pressure: hold out_ready = 0 for 10 cycles in DONE, pulse in_valid with different data -> state_o stable, new data not accepted. On out_ready = 1, return to IDLE and accept the next block.
5. Assert rst_n = 0 for one cycle during the 2nd compute cycle -> out_valid = 0, state_o = 0, in_ready = 1 after release. A fresh block then yields the correct result.
6. With MIX_COLUMNS_SEQ_BYPASS_EN defined, bypass_i = 1, input 0123456789abcdeffedcba9876543210 -> out_valid one cycle after accept, state_o identical to the input.
